clint_regs: RTL and testbench
=============================

# clint_regs

Core-local interruptor register file. Sits directly downstream of the AXI4-Lite slave adapter and consumes its single-beat, full-word, RAM-like access port. Holds the 64-bit `mtime` counter, per-hart `mtimecmp` and `msip` registers, and drives per-hart timer and software interrupts. `mtime` advances on rising edges of an external, asynchronous RTC signal.

## Interface
- `NR_CORES`, default 1: number of harts, legal range 1..4095.
- `AXI_ADDR_WIDTH`, default 64: access-port address width.
- `AXI_DATA_WIDTH`, default 64: access-port data width; only 64 is supported, and an elaboration-time assertion enforces it.

Ports:
- `clk_i`  in  1  clock
- `rst_ni`  in  1  reset, asynchronous, active-low
- `address_i`  in  AXI_ADDR_WIDTH  word address of the access
- `en_i`  in  1  access valid this cycle
- `we_i`  in  1  access is a write (qualified by `en_i`)
- `wdata_i`  in  64  write data, full word, no byte strobes
- `rdata_o`  out  64  read data, combinational
- `rtc_i`  in  1  asynchronous real-time clock; one `mtime` tick per rising edge
- `timer_irq_o`  out  NR_CORES  machine timer interrupt, one bit per hart
- `ipi_o`  out  NR_CORES  machine software interrupt, one bit per hart

## Operation
Decode uses `address_i[15:3]` as the 64-bit word index. Bits [2:0] are ignored, and bits above 15 are ignored because the system crossbar already selected this slave.

- **MSIP, 0x0000 + 8·w, for w < ceil(NR_CORES/2):**
  - Word w holds `msip[2w]` at bit 0 and `msip[2w+1]` at bit 32. All other bits read 0.
  - A write updates both bits. Bits belonging to non-existent harts read 0 and ignore writes.
- **MTIMECMP, 0x4000 + 8·h, for h < NR_CORES:** full 64-bit read/write.
- **MTIME, 0xBFF8:** full 64-bit read/write.
- **Any other word:** reads 0, writes ignored, no error.

Reads:
- When `en_i`=1 and `we_i`=0, `rdata_o` is the current registered value of the decoded word.
- `rdata_o` is 0 when `en_i`=0.
- Reads have no side effects.

Writes:
- When `en_i`=1 and `we_i`=1, the decoded register takes `wdata_i` at the next rising clock edge.

RTC path:
- `rtc_i` goes through a 2-flop synchronizer (`s1`, `s2`), followed by a registered copy of `s2` (`s3`).
- The tick is `s2 & ~s3`.
- On a tick, `mtime` ← `mtime`+1, modulo 2^64: 0xFFFF_FFFF_FFFF_FFFF wraps to 0.

Simultaneous events:
- A software write to MTIME in the same cycle as a tick wins. `mtime` takes `wdata_i` and the tick is lost.
- A read of MTIME in a tick cycle returns the pre-increment value.

Interrupts:
- `timer_irq_o[h]` is registered from (`mtime` ≥ `mtimecmp[h]`), an unsigned 64-bit compare on registered values.
- `ipi_o[h]` is registered from `msip[h]`.

Reset values:
- `mtime` = 0.
- `mtimecmp[*]` = 0xFFFF_FFFF_FFFF_FFFF, so no timer interrupt fires out of reset.
- `msip[*]` = 0.
- Synchronizer flops = 0.
- `timer_irq_o` = 0, `ipi_o` = 0, `rdata_o` = 0.

Reset asserted mid-operation returns every register to these values immediately (asynchronous reset). A pending access is dropped.

## Timing
- Read latency is 0 cycles: `rdata_o` is valid in the same cycle as `en_i`. The upstream adapter holds `address_i`/`en_i` for the whole R-valid phase, and `rdata_o` must stay stable while they are held unless `mtime` ticks.
- A write in cycle N is visible on `rdata_o` in cycle N+1.
- Interrupt latency from a register write:
  - The write in cycle N updates the register at edge N+1.
  - The interrupt output changes at edge N+2.
  - Example: `msip[0]` written 1 in cycle N gives `ipi_o[0]`=1 from cycle N+2.
- RTC latency: with `rtc_i` rising and meeting setup before edge E, `s2`=1 after E+1, the tick is active in the cycle after E+1, and the `mtime` increment is visible after E+2. `timer_irq_o` follows one cycle later, after E+3.
- `rtc_i` high and low phases must each be ≥ 2 `clk_i` cycles. Faster toggling may drop ticks, which is not detected.
- No back-pressure: every access completes in one cycle.

## Test plan
- **Reset:** release `rst_ni` and read 0xBFF8, 0x4000 and 0x0000 → 0, 0xFFFF_FFFF_FFFF_FFFF and 0. `timer_irq_o`=0 and `ipi_o`=0.
- **MSIP packing** (NR_CORES=3):
  - Write 0x0000 with 0x0000_0001_0000_0001 → `ipi_o`=3'b011 two cycles later.
  - Write 0x0008 with 0xFFFF_FFFF_FFFF_FFFF, then read it → 0x0000_0000_0000_0001.
- **Timer compare:**
  - Write `mtimecmp[0]`=5 and toggle `rtc_i` 5 times → `timer_irq_o[0]` rises exactly one cycle after `mtime` reads 5.
  - Write `mtimecmp[0]`=0xFFFF_FFFF_FFFF_FFFF → `timer_irq_o[0]` clears two cycles later.
- **Wrap:** write MTIME=0xFFFF_FFFF_FFFF_FFFF, then apply one `rtc_i` rising edge → MTIME reads 0 three edges later.
- **Collision:** align an `rtc_i` tick with a write of MTIME=0x100 → MTIME reads 0x100, not 0x101.
- **Unmapped:** write 0x8000 and read it back → 0. Write `mtimecmp` for h=NR_CORES → ignored, and all existing registers are unchanged.

Source files
------------

// File: rtl/clint_regs.sv
`default_nettype none
// ============================================================================
// Module   : clint_regs
// Brief    : Core-local interruptor registers: mtime, per-hart mtimecmp/msip,
//            timer and software interrupt outputs, RTC-driven mtime ticks.
// Revision : 1.0 - initial release
// ============================================================================
module clint_regs #(
  parameter int unsigned NR_CORES       = 1,
  parameter int unsigned AXI_ADDR_WIDTH = 64,
  parameter int unsigned AXI_DATA_WIDTH = 64
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic [AXI_ADDR_WIDTH-1:0] address_i,
  input  logic                      en_i,
  input  logic                      we_i,
  input  logic [63:0]               wdata_i,
  output logic [63:0]               rdata_o,
  input  logic                      rtc_i,
  output logic [NR_CORES-1:0]       timer_irq_o,
  output logic [NR_CORES-1:0]       ipi_o
);

  localparam logic [12:0] c_MTIMECMP_BASE = 13'h0800;
  localparam logic [12:0] c_MTIME_WORD    = 13'h17FF;

  if (AXI_DATA_WIDTH != 64) begin : g_data_width_check
    $error("clint_regs: AXI_DATA_WIDTH must be 64");
  end

  if (AXI_ADDR_WIDTH < 16) begin : g_addr_width_check
    $error("clint_regs: AXI_ADDR_WIDTH must be at least 16");
  end

  if (NR_CORES < 1 || NR_CORES > 4095) begin : g_nr_cores_check
    $error("clint_regs: NR_CORES must be in 1..4095");
  end

  // Upper address bits were already decoded by the crossbar.
  if (AXI_ADDR_WIDTH > 16) begin : g_addr_hi
    logic w_unused_addr_hi;
    assign w_unused_addr_hi = ^address_i[AXI_ADDR_WIDTH-1:16];
  end

  logic w_unused_addr_lo;
  assign w_unused_addr_lo = ^address_i[2:0];

  logic [12:0]         w_word;
  logic                w_wr;
  logic                w_mtime_sel;
  logic                w_tick;
  logic [63:0]         w_rdata;

  logic [63:0]         mtime_d;
  logic [63:0]         mtime_q;
  logic [63:0]         mtimecmp_q [NR_CORES];
  logic [NR_CORES-1:0] msip_q;
  logic [NR_CORES-1:0] timer_irq_q;
  logic [NR_CORES-1:0] ipi_q;
  logic                rtc_s1_q;
  logic                rtc_s2_q;
  logic                rtc_s3_q;

  assign w_word      = address_i[15:3];
  assign w_wr        = en_i & we_i;
  assign w_mtime_sel = (w_word == c_MTIME_WORD);
  assign w_tick      = rtc_s2_q & ~rtc_s3_q;

  // Hart h's msip lives in word h/2, at bit 0 for even h and bit 32 for odd h.
  always_comb begin
    w_rdata = '0;
    if (en_i && !we_i) begin
      if (w_mtime_sel) begin
        w_rdata = mtime_q;
      end
      for (int h = 0; h < NR_CORES; h++) begin
        if (w_word == c_MTIMECMP_BASE + 13'(h)) begin
          w_rdata = mtimecmp_q[h];
        end
        if (w_word == 13'(h >> 1)) begin
          w_rdata[(h % 2) * 32] = msip_q[h];
        end
      end
    end
  end

  // A software write to mtime takes priority over a coincident tick.
  always_comb begin
    mtime_d = mtime_q;
    if (w_wr && w_mtime_sel) begin
      mtime_d = wdata_i;
    end else if (w_tick) begin
      mtime_d = mtime_q + 64'd1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rtc_s1_q    <= 1'b0;
      rtc_s2_q    <= 1'b0;
      rtc_s3_q    <= 1'b0;
      mtime_q     <= '0;
      msip_q      <= '0;
      timer_irq_q <= '0;
      ipi_q       <= '0;
      for (int h = 0; h < NR_CORES; h++) begin
        mtimecmp_q[h] <= '1;
      end
    end else begin
      rtc_s1_q <= rtc_i;
      rtc_s2_q <= rtc_s1_q;
      rtc_s3_q <= rtc_s2_q;
      mtime_q  <= mtime_d;
      ipi_q    <= msip_q;
      for (int h = 0; h < NR_CORES; h++) begin
        if (w_wr && (w_word == c_MTIMECMP_BASE + 13'(h))) begin
          mtimecmp_q[h] <= wdata_i;
        end
        if (w_wr && (w_word == 13'(h >> 1))) begin
          msip_q[h] <= wdata_i[(h % 2) * 32];
        end
        timer_irq_q[h] <= (mtime_q >= mtimecmp_q[h]);
      end
    end
  end

  assign rdata_o     = w_rdata;
  assign timer_irq_o = timer_irq_q;
  assign ipi_o       = ipi_q;

endmodule
`default_nettype wire

// File: tb/tb_clint_regs.sv
`default_nettype none
// ============================================================================
// Module   : tb_clint_regs
// Brief    : Directed self-checking bench for clint_regs with three harts.
// Revision : 1.0 - initial release
// ============================================================================
module tb_clint_regs;

  localparam int unsigned NR_CORES = 3;

  logic                clk;
  logic                rst_n;
  logic [63:0]         address;
  logic                en;
  logic                we;
  logic [63:0]         wdata;
  logic [63:0]         rdata;
  logic                rtc;
  logic [NR_CORES-1:0] timer_irq;
  logic [NR_CORES-1:0] ipi;

  int checks = 0;
  int errors = 0;

  clint_regs #(
    .NR_CORES       (NR_CORES),
    .AXI_ADDR_WIDTH (64),
    .AXI_DATA_WIDTH (64)
  ) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .address_i   (address),
    .en_i        (en),
    .we_i        (we),
    .wdata_i     (wdata),
    .rdata_o     (rdata),
    .rtc_i       (rtc),
    .timer_irq_o (timer_irq),
    .ipi_o       (ipi)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic do_write(input logic [63:0] a, input logic [63:0] d);
    @(negedge clk);
    address = a;
    wdata   = d;
    en      = 1'b1;
    we      = 1'b1;
    @(negedge clk);
    en = 1'b0;
    we = 1'b0;
  endtask

  task automatic do_read(input logic [63:0] a, output logic [63:0] d);
    @(negedge clk);
    address = a;
    en      = 1'b1;
    we      = 1'b0;
    #1;
    d  = rdata;
    en = 1'b0;
  endtask

  task automatic rtc_pulse();
    @(negedge clk);
    rtc = 1'b1;
    repeat (3) @(negedge clk);
    rtc = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset();
    logic [63:0] d;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++;
    if (timer_irq !== 3'b000 || ipi !== 3'b000) begin
      errors++;
      $display("FAIL reset_irqs: timer_irq=%b ipi=%b, expected 000/000", timer_irq, ipi);
    end
    checks++;
    if (rdata !== 64'h0) begin
      errors++;
      $display("FAIL reset_rdata_idle: got %h expected 0", rdata);
    end
    do_read(64'hBFF8, d);
    checks++;
    if (d !== 64'h0) begin
      errors++;
      $display("FAIL reset_mtime: got %h expected 0", d);
    end
    do_read(64'h4000, d);
    checks++;
    if (d !== 64'hFFFF_FFFF_FFFF_FFFF) begin
      errors++;
      $display("FAIL reset_mtimecmp: got %h expected ffffffffffffffff", d);
    end
    do_read(64'h0000, d);
    checks++;
    if (d !== 64'h0) begin
      errors++;
      $display("FAIL reset_msip: got %h expected 0", d);
    end
  endtask

  task automatic test_msip();
    logic [63:0] d;
    @(negedge clk);
    address = 64'h0000;
    wdata   = 64'h0000_0001_0000_0001;
    en      = 1'b1;
    we      = 1'b1;
    @(negedge clk);
    en = 1'b0;
    we = 1'b0;
    #1;
    checks++;
    if (ipi !== 3'b000) begin
      errors++;
      $display("FAIL msip_ipi_early: got %b expected 000", ipi);
    end
    @(negedge clk);
    #1;
    checks++;
    if (ipi !== 3'b011) begin
      errors++;
      $display("FAIL msip_ipi_pair: got %b expected 011", ipi);
    end
    do_read(64'h0000, d);
    checks++;
    if (d !== 64'h0000_0001_0000_0001) begin
      errors++;
      $display("FAIL msip_word0: got %h expected 0000000100000001", d);
    end
    do_write(64'h0008, 64'hFFFF_FFFF_FFFF_FFFF);
    do_read(64'h0008, d);
    checks++;
    if (d !== 64'h0000_0000_0000_0001) begin
      errors++;
      $display("FAIL msip_word1: got %h expected 0000000000000001", d);
    end
    #1;
    checks++;
    if (ipi !== 3'b111) begin
      errors++;
      $display("FAIL msip_ipi_all: got %b expected 111", ipi);
    end
  endtask

  task automatic test_timer();
    logic [63:0] d;
    int first;
    do_write(64'hBFF8, 64'h0);
    do_write(64'h4000, 64'd5);
    repeat (4) rtc_pulse();
    do_read(64'hBFF8, d);
    checks++;
    if (d !== 64'd4) begin
      errors++;
      $display("FAIL timer_mtime4: got %h expected 4", d);
    end
    checks++;
    if (timer_irq[0] !== 1'b0) begin
      errors++;
      $display("FAIL timer_irq_below: got %b expected 0", timer_irq[0]);
    end
    @(negedge clk);
    rtc     = 1'b1;
    address = 64'hBFF8;
    en      = 1'b1;
    we      = 1'b0;
    first   = 0;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      #1;
      if (first == 0 && rdata === 64'd5) begin
        first = k;
        checks++;
        if (k != 3) begin
          errors++;
          $display("FAIL timer_rtc_latency: mtime=5 seen after %0d edges, expected 3", k);
        end
        checks++;
        if (timer_irq[0] !== 1'b0) begin
          errors++;
          $display("FAIL timer_irq_same_cycle: got %b expected 0", timer_irq[0]);
        end
      end else if (first != 0) begin
        checks++;
        if (timer_irq[0] !== 1'b1) begin
          errors++;
          $display("FAIL timer_irq_rise: got %b expected 1", timer_irq[0]);
        end
        break;
      end
    end
    if (first == 0) begin
      checks++;
      errors++;
      $display("FAIL timer_timeout: mtime never read 5, last %h", rdata);
    end
    en  = 1'b0;
    rtc = 1'b0;
    repeat (3) @(negedge clk);
    @(negedge clk);
    address = 64'h4000;
    wdata   = 64'hFFFF_FFFF_FFFF_FFFF;
    en      = 1'b1;
    we      = 1'b1;
    @(negedge clk);
    en = 1'b0;
    we = 1'b0;
    #1;
    checks++;
    if (timer_irq[0] !== 1'b1) begin
      errors++;
      $display("FAIL timer_clear_early: got %b expected 1", timer_irq[0]);
    end
    @(negedge clk);
    #1;
    checks++;
    if (timer_irq[0] !== 1'b0) begin
      errors++;
      $display("FAIL timer_clear: got %b expected 0", timer_irq[0]);
    end
  endtask

  task automatic test_wrap();
    do_write(64'hBFF8, 64'hFFFF_FFFF_FFFF_FFFF);
    @(negedge clk);
    rtc = 1'b1;
    @(negedge clk);
    @(negedge clk);
    address = 64'hBFF8;
    en      = 1'b1;
    we      = 1'b0;
    #1;
    checks++;
    if (rdata !== 64'hFFFF_FFFF_FFFF_FFFF) begin
      errors++;
      $display("FAIL wrap_pre_increment: got %h expected ffffffffffffffff", rdata);
    end
    @(negedge clk);
    #1;
    checks++;
    if (rdata !== 64'h0) begin
      errors++;
      $display("FAIL wrap_zero: got %h expected 0", rdata);
    end
    en  = 1'b0;
    rtc = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_collision();
    logic [63:0] d;
    @(negedge clk);
    rtc = 1'b1;
    @(negedge clk);
    @(negedge clk);
    address = 64'hBFF8;
    wdata   = 64'h100;
    en      = 1'b1;
    we      = 1'b1;
    @(negedge clk);
    en = 1'b0;
    we = 1'b0;
    do_read(64'hBFF8, d);
    checks++;
    if (d !== 64'h100) begin
      errors++;
      $display("FAIL collision_write_wins: got %h expected 100", d);
    end
    rtc = 1'b0;
    repeat (4) @(negedge clk);
    do_read(64'hBFF8, d);
    checks++;
    if (d !== 64'h100) begin
      errors++;
      $display("FAIL collision_no_late_tick: got %h expected 100", d);
    end
  endtask

  task automatic test_multi_hart();
    logic [63:0] d;
    do_write(64'h4008, 64'h80);
    do_write(64'h4010, 64'h200);
    do_read(64'h4010, d);
    checks++;
    if (d !== 64'h200) begin
      errors++;
      $display("FAIL multi_cmp2: got %h expected 200", d);
    end
    #1;
    checks++;
    if (timer_irq !== 3'b010) begin
      errors++;
      $display("FAIL multi_irq: got %b expected 010", timer_irq);
    end
    do_read(64'h0000_0001_0000_400C, d);
    checks++;
    if (d !== 64'h80) begin
      errors++;
      $display("FAIL multi_alias_cmp1: got %h expected 80", d);
    end
  endtask

  task automatic test_unmapped();
    logic [63:0] d;
    do_write(64'h8000, 64'hDEAD_BEEF_0000_0001);
    do_write(64'h4018, 64'h1234);
    do_write(64'h0010, 64'hFFFF_FFFF_FFFF_FFFF);
    do_read(64'h8000, d);
    checks++;
    if (d !== 64'h0) begin
      errors++;
      $display("FAIL unmapped_8000: got %h expected 0", d);
    end
    do_read(64'h4018, d);
    checks++;
    if (d !== 64'h0) begin
      errors++;
      $display("FAIL unmapped_cmp3: got %h expected 0", d);
    end
    do_read(64'h0010, d);
    checks++;
    if (d !== 64'h0) begin
      errors++;
      $display("FAIL unmapped_msip2: got %h expected 0", d);
    end
    do_read(64'h4000, d);
    checks++;
    if (d !== 64'hFFFF_FFFF_FFFF_FFFF) begin
      errors++;
      $display("FAIL unmapped_keep_cmp0: got %h expected ffffffffffffffff", d);
    end
    do_read(64'h4008, d);
    checks++;
    if (d !== 64'h80) begin
      errors++;
      $display("FAIL unmapped_keep_cmp1: got %h expected 80", d);
    end
    do_read(64'h4010, d);
    checks++;
    if (d !== 64'h200) begin
      errors++;
      $display("FAIL unmapped_keep_cmp2: got %h expected 200", d);
    end
    do_read(64'h0000, d);
    checks++;
    if (d !== 64'h0000_0001_0000_0001) begin
      errors++;
      $display("FAIL unmapped_keep_msip0: got %h expected 0000000100000001", d);
    end
    do_read(64'h0008, d);
    checks++;
    if (d !== 64'h1) begin
      errors++;
      $display("FAIL unmapped_keep_msip1: got %h expected 1", d);
    end
    do_read(64'hBFF8, d);
    checks++;
    if (d !== 64'h100) begin
      errors++;
      $display("FAIL unmapped_keep_mtime: got %h expected 100", d);
    end
    @(negedge clk);
    address = 64'h4008;
    en      = 1'b0;
    #1;
    checks++;
    if (rdata !== 64'h0 || ipi !== 3'b111 || timer_irq !== 3'b010) begin
      errors++;
      $display("FAIL unmapped_idle: rdata=%h ipi=%b irq=%b expected 0/111/010",
               rdata, ipi, timer_irq);
    end
  endtask

  task automatic test_async_reset();
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (ipi !== 3'b000 || timer_irq !== 3'b000) begin
      errors++;
      $display("FAIL async_reset_irqs: ipi=%b irq=%b expected 000/000", ipi, timer_irq);
    end
    address = 64'h4008;
    en      = 1'b1;
    we      = 1'b0;
    #1;
    checks++;
    if (rdata !== 64'hFFFF_FFFF_FFFF_FFFF) begin
      errors++;
      $display("FAIL async_reset_cmp1: got %h expected ffffffffffffffff", rdata);
    end
    address = 64'hBFF8;
    #1;
    checks++;
    if (rdata !== 64'h0) begin
      errors++;
      $display("FAIL async_reset_mtime: got %h expected 0", rdata);
    end
    en = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    rst_n   = 1'b0;
    address = '0;
    en      = 1'b0;
    we      = 1'b0;
    wdata   = '0;
    rtc     = 1'b0;
    test_reset();
    test_msip();
    test_timer();
    test_wrap();
    test_collision();
    test_multi_hart();
    test_unmapped();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
